// File: rtl/switch_router_pkg.sv
// Shared types and helpers for the break-before-make signal router.
package switch_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DEAD   = 2'b10
  } state_e;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/dead_time_counter.sv
// Down-counter timing the all-off interval; last flags the final dead cycle.
module dead_time_counter
  import switch_router_pkg::*;
#(
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic last
);

  localparam int CNT_W = clog2(DEAD_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Only loaded or decremented while nonzero, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst)                        count <= '0;
    else if (load)                  count <= CNT_W'(DEAD_CYCLES);
    else if (tick && count != '0)   count <= count - 1'b1;
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/switch_router.sv
// Registered N-group signal router; every group entry passes an all-off dead interval.
module switch_router
  import switch_router_pkg::*;
#(
  parameter int N_GROUPS    = 2,
  parameter int N_SIG       = 2,
  parameter int DEAD_CYCLES = 4,
  parameter int SEL_W       = clog2(N_GROUPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [SEL_W-1:0]          sel,
  input  logic [N_SIG-1:0]          sig_in,
  output logic [N_GROUPS*N_SIG-1:0] sig_out,
  output logic [SEL_W-1:0]          active_grp,
  output logic                      busy,
  output logic                      sel_err
);

  state_e           state;
  logic [SEL_W-1:0] target;
  logic             sel_ok;
  logic             last;
  logic             load;
  logic             tick;

  assign sel_ok = (int'(sel) < N_GROUPS);

  // Place the bundle in one slice; every other slice stays zero.
  function automatic logic [N_GROUPS*N_SIG-1:0] route(input logic [SEL_W-1:0] g,
                                                       input logic [N_SIG-1:0]  d);
    logic [N_GROUPS*N_SIG-1:0] r;
    r = '0;
    for (int i = 0; i < N_GROUPS; i++)
      if (g == SEL_W'(i)) r[i*N_SIG +: N_SIG] = d;
    return r;
  endfunction

  always_comb begin
    load = 1'b0;
    if (en && sel_ok) begin
      case (state)
        ST_IDLE:   load = 1'b1;
        ST_ACTIVE: load = (sel != active_grp);
        default:   load = 1'b0;
      endcase
    end
    tick = en && (state == ST_DEAD);
  end

  dead_time_counter #(.DEAD_CYCLES(DEAD_CYCLES)) u_dead (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .tick (tick),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      target     <= '0;
      active_grp <= '0;
      sig_out    <= '0;
      busy       <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      sel_err <= !sel_ok;
      case (state)
        ST_IDLE: begin
          sig_out <= '0;
          busy    <= 1'b0;
          if (en && sel_ok) begin
            state  <= ST_DEAD;
            target <= sel;
            busy   <= 1'b1;
          end
        end
        ST_DEAD: begin
          sig_out <= '0;
          if (!en) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            // A select arriving on the final dead edge still wins the target.
            state      <= ST_ACTIVE;
            busy       <= 1'b0;
            target     <= sel_ok ? sel : target;
            active_grp <= sel_ok ? sel : target;
            sig_out    <= route(sel_ok ? sel : target, sig_in);
          end else if (sel_ok) begin
            target <= sel;
          end
        end
        ST_ACTIVE: begin
          if (!en) begin
            state   <= ST_IDLE;
            sig_out <= '0;
          end else if (sel_ok && sel != active_grp) begin
            state   <= ST_DEAD;
            target  <= sel;
            busy    <= 1'b1;
            sig_out <= '0;
          end else begin
            sig_out <= route(active_grp, sig_in);
          end
        end
        default: begin
          state   <= ST_IDLE;
          sig_out <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_router.sv
// Directed bench: a 2-group and a 3-group router share clock, reset, enable and data.
module tb_switch_router;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] sig_in = 2'b00;
  logic       sel2 = 1'b0;
  logic [1:0] sel3 = 2'b00;

  logic [3:0] sig_out2;
  logic       active_grp2;
  logic       busy2, sel_err2;
  logic [5:0] sig_out3;
  logic [1:0] active_grp3;
  logic       busy3, sel_err3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  switch_router #(.N_GROUPS(2), .N_SIG(2), .DEAD_CYCLES(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .sel(sel2), .sig_in(sig_in),
    .sig_out(sig_out2), .active_grp(active_grp2), .busy(busy2), .sel_err(sel_err2)
  );

  switch_router #(.N_GROUPS(3), .N_SIG(2), .DEAD_CYCLES(4)) dut3 (
    .clk(clk), .rst(rst), .en(en), .sel(sel3), .sig_in(sig_in),
    .sig_out(sig_out3), .active_grp(active_grp3), .busy(busy3), .sel_err(sel_err3)
  );

  // Break-before-make monitor: never more than one live slice.
  always @(negedge clk) begin
    int nz2, nz3;
    nz2 = 0; nz3 = 0;
    for (int g = 0; g < 2; g++) if (sig_out2[g*2 +: 2] != 2'b00) nz2++;
    for (int g = 0; g < 3; g++) if (sig_out3[g*2 +: 2] != 2'b00) nz3++;
    checks++;
    if (nz2 > 1 || nz3 > 1) begin
      failures++;
      $display("FAIL overlap: sig_out2=%b sig_out3=%b, required at most one live slice", sig_out2, sig_out3);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sel2 = 1'b0; sel3 = 2'd0; sig_in = 2'b00;
    step(); step();
    checks++; if (sig_out2 !== 4'b0000) begin failures++; $display("FAIL reset_sig_out2: got %b expected 0000", sig_out2); end
    checks++; if (active_grp2 !== 1'b0) begin failures++; $display("FAIL reset_grp2: got %b expected 0", active_grp2); end
    checks++; if (busy2 !== 1'b0 || sel_err2 !== 1'b0) begin failures++; $display("FAIL reset_flags2: busy=%b sel_err=%b expected 0 0", busy2, sel_err2); end
    checks++; if (sig_out3 !== 6'b0 || active_grp3 !== 2'd0 || busy3 !== 1'b0) begin failures++; $display("FAIL reset_dut3: sig_out=%b grp=%0d busy=%b expected 0 0 0", sig_out3, active_grp3, busy3); end
    rst = 1'b0; en = 1'b1; sel2 = 1'b0; sel3 = 2'd0; sig_in = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (sig_out2 !== 4'b0000 || busy2 !== 1'b1) begin failures++; $display("FAIL enable_dead[%0d]: sig_out=%b busy=%b expected 0000 1", i, sig_out2, busy2); end
    end
    step();
    checks++; if (sig_out2 !== 4'b0011) begin failures++; $display("FAIL enable_drive: got %b expected 0011", sig_out2); end
    checks++; if (active_grp2 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL enable_state: grp=%b busy=%b expected 0 0", active_grp2, busy2); end
    checks++; if (sig_out3 !== 6'b000011) begin failures++; $display("FAIL enable_drive3: got %b expected 000011", sig_out3); end
  endtask

  task automatic test_switch();
    sel2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (sig_out2 !== 4'b0000 || busy2 !== 1'b1) begin failures++; $display("FAIL switch_gap[%0d]: sig_out=%b busy=%b expected 0000 1", i, sig_out2, busy2); end
    end
    step();
    checks++; if (sig_out2 !== 4'b1100 || active_grp2 !== 1'b1) begin failures++; $display("FAIL switch_drive: sig_out=%b grp=%b expected 1100 1", sig_out2, active_grp2); end
  endtask

  task automatic test_data_path();
    sig_in = 2'b01; step();
    checks++; if (sig_out2 !== 4'b0100) begin failures++; $display("FAIL data_01: got %b expected 0100", sig_out2); end
    sig_in = 2'b10; step();
    checks++; if (sig_out2 !== 4'b1000) begin failures++; $display("FAIL data_10: got %b expected 1000", sig_out2); end
    sig_in = 2'b11; step();
    checks++; if (sig_out2 !== 4'b1100) begin failures++; $display("FAIL data_11: got %b expected 1100", sig_out2); end
  endtask

  task automatic test_retarget();
    sel3 = 2'd1;
    step();
    checks++; if (sig_out3 !== 6'b0 || busy3 !== 1'b1) begin failures++; $display("FAIL retarget_enter: sig_out=%b busy=%b expected 000000 1", sig_out3, busy3); end
    sel3 = 2'd2;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (sig_out3 !== 6'b0) begin failures++; $display("FAIL retarget_gap[%0d]: got %b expected 000000", i, sig_out3); end
    end
    step();
    checks++; if (sig_out3 !== 6'b110000 || active_grp3 !== 2'd2) begin failures++; $display("FAIL retarget_drive: sig_out=%b grp=%0d expected 110000 2", sig_out3, active_grp3); end
  endtask

  task automatic test_invalid_sel();
    sel3 = 2'd1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (sig_out3 !== 6'b001100 || active_grp3 !== 2'd1) begin failures++; $display("FAIL invalid_setup: sig_out=%b grp=%0d expected 001100 1", sig_out3, active_grp3); end
    sel3 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (sel_err3 !== 1'b1) begin failures++; $display("FAIL invalid_err[%0d]: got %b expected 1", i, sel_err3); end
      checks++; if (sig_out3 !== 6'b001100 || busy3 !== 1'b0) begin failures++; $display("FAIL invalid_hold[%0d]: sig_out=%b busy=%b expected 001100 0", i, sig_out3, busy3); end
    end
    sel3 = 2'd1;
    step();
    checks++; if (sel_err3 !== 1'b0 || sig_out3 !== 6'b001100) begin failures++; $display("FAIL invalid_clear: sel_err=%b sig_out=%b expected 0 001100", sel_err3, sig_out3); end
  endtask

  task automatic test_disable_mid_dead();
    sel2 = 1'b0;
    step();
    checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL dis_dead1: busy=%b expected 1", busy2); end
    en = 1'b0;
    step();
    checks++; if (sig_out2 !== 4'b0000 || busy2 !== 1'b0) begin failures++; $display("FAIL dis_idle: sig_out=%b busy=%b expected 0000 0", sig_out2, busy2); end
    checks++; if (sig_out3 !== 6'b0) begin failures++; $display("FAIL dis_idle3: got %b expected 000000", sig_out3); end
    step();
    checks++; if (sig_out2 !== 4'b0000 || busy2 !== 1'b0) begin failures++; $display("FAIL dis_stay: sig_out=%b busy=%b expected 0000 0", sig_out2, busy2); end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (sig_out2 !== 4'b0000 || busy2 !== 1'b1) begin failures++; $display("FAIL reen_gap[%0d]: sig_out=%b busy=%b expected 0000 1", i, sig_out2, busy2); end
    end
    step();
    checks++; if (sig_out2 !== 4'b0011) begin failures++; $display("FAIL reen_drive: got %b expected 0011", sig_out2); end
    checks++; if (sig_out3 !== 6'b001100) begin failures++; $display("FAIL reen_drive3: got %b expected 001100", sig_out3); end
  endtask

  task automatic test_rst_active();
    rst = 1'b1;
    step();
    checks++; if (sig_out3 !== 6'b0 || active_grp3 !== 2'd0) begin failures++; $display("FAIL rst_active3: sig_out=%b grp=%0d expected 000000 0", sig_out3, active_grp3); end
    checks++; if (busy3 !== 1'b0 || sel_err3 !== 1'b0 || sig_out2 !== 4'b0000) begin failures++; $display("FAIL rst_active_misc: busy3=%b sel_err3=%b sig_out2=%b expected 0 0 0000", busy3, sel_err3, sig_out2); end
    rst = 1'b0;
  endtask

  task automatic test_en_invalid();
    en = 1'b0; sel3 = 2'd3;
    step();
    en = 1'b1;
    step();
    checks++; if (sel_err3 !== 1'b1 || busy3 !== 1'b0 || sig_out3 !== 6'b0) begin failures++; $display("FAIL en_invalid: sel_err=%b busy=%b sig_out=%b expected 1 0 000000", sel_err3, busy3, sig_out3); end
    step();
    checks++; if (busy3 !== 1'b0 || sig_out3 !== 6'b0) begin failures++; $display("FAIL en_invalid_stay: busy=%b sig_out=%b expected 0 000000", busy3, sig_out3); end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_data_path();
    test_retarget();
    test_invalid_sel();
    test_disable_mid_dead();
    test_rst_active();
    test_en_invalid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_router.md
# switch_router

Parametrised, registered signal router with break-before-make dead time. It steers an N_SIG-bit drive bundle to exactly one of N_GROUPS output groups, chosen by `sel`, so that in the two-group default one driver pair selects the frequency path (group 0) and the other the current path (group 1). Every group change, and every enable, passes through an all-off dead-time interval, so two groups are never driven in the same cycle. It sits between the drive-pattern generators and the output pins.

## Interface
- `N_GROUPS`, default 2: number of output groups; minimum 2.
- `N_SIG`, default 2: signals per group.
- `DEAD_CYCLES`, default 4: all-off cycles on every group entry; minimum 1.
- `SEL_W`, derived as clog2(N_GROUPS): select width; not overridden.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: routing enable; when 0, all outputs are off.
- `sel`, in, SEL_W: requested group.
- `sig_in`, in, N_SIG: drive bundle to route.
- `sig_out`, out, N_GROUPS*N_SIG: group g occupies bits [g*N_SIG +: N_SIG].
- `active_grp`, out, SEL_W: group currently driven, or last committed target.
- `busy`, out, 1: high while in DEAD.
- `sel_err`, out, 1: `sel` >= N_GROUPS was sampled on the previous edge.

## Operation
- **Reset values:** state=IDLE, `sig_out`=0, `active_grp`=0, `busy`=0, `sel_err`=0, dead counter=0, target=0.
- A valid select is `sel` < N_GROUPS. An invalid select is ignored for routing, and `sel_err` is 1 for every cycle in which it is sampled.
- **IDLE:** `sig_out`=0.
  - `en`=1 and valid `sel` → DEAD; target=`sel`; counter=DEAD_CYCLES.
  - Otherwise remain in IDLE.
- **DEAD:** `sig_out`=0, `busy`=1, counter decrements each cycle.
  - `en`=0 → IDLE immediately.
  - A new valid `sel` updates the target but does not reload the counter.
  - Counter==1 and `en`=1 → ACTIVE; `active_grp`=target.
- **ACTIVE:** slice `active_grp` = `sig_in`; all other slices = 0.
  - `en`=0 → IDLE.
  - Valid `sel` != `active_grp` → DEAD; target=`sel`; counter=DEAD_CYCLES.
  - Invalid `sel` → remain in ACTIVE on the same group.
- **Priority:** `rst` > `en`=0 > select change > hold.
- **Safety invariant:** at most one slice of `sig_out` is ever nonzero.

## Timing
- All outputs are registered. Inputs sampled at edge k are reflected in the outputs after edge k.
- **ACTIVE latency:** 1 cycle from `sig_in` to `sig_out`.
- **Group switch:** `sel` changes and is sampled at edge k.
  - After edge k, `sig_out`=0 and `busy`=1.
  - The new slice is driven after edge k+DEAD_CYCLES, using `sig_in` sampled at that edge.
  - The all-off gap is exactly DEAD_CYCLES cycles.
- **Enable from IDLE:** same sequence as a group switch, so the first drive appears after edge k+DEAD_CYCLES.
- **`en` deasserted at edge k:** `sig_out`=0 after edge k with no delay. Re-enabling restarts a full dead interval.
- **Simultaneous `en` rise and invalid `sel`:** remain in IDLE; `sel_err`=1.
- **Mid-operation `rst`:** all outputs return to their reset values after that edge, regardless of state or counter value.
- **Counter:** width clog2(DEAD_CYCLES+1); no wrap, because it is only loaded or decremented while nonzero.

## Structure
- Shared package `switch_router_pkg` holds:
  - state encoding: IDLE=2'b00, ACTIVE=2'b01, DEAD=2'b10; 2'b11 recovers to IDLE;
  - the clog2 constant function.
- One sub-module, `dead_time_counter`.
  - Inputs: `load`, `tick`. Output: `last` (count==1).
  - Parameter: DEAD_CYCLES.
- The top level holds the FSM, target register, output slice generation and `sel_err`.

## Test plan
- **Reset/enable:** defaults; `rst` for 2 cycles, then `en`=1, `sel`=0, `sig_in`=2'b11 → `sig_out`=4'b0000 and `busy`=1 for 4 cycles, then `sig_out`=4'b0011, `active_grp`=0.
- **Switch:** in ACTIVE on group 0, set `sel`=1 → `sig_out`=0 for exactly 4 cycles, then 4'b1100. A monitor asserts no overlap on every cycle.
- **Retarget in DEAD:** N_GROUPS=3, `sel` 0→1, then →2 at the second dead cycle → group 2 is driven 4 cycles after the first change (counter not reloaded); group 1 is never driven.
- **Invalid select:** N_GROUPS=3, ACTIVE on group 1, `sel`=3 for 3 cycles → `sel_err`=1 for 3 cycles; group 1 stays driven; no DEAD entry.
- **Disable/reset mid-dead:** `en`=0 at dead cycle 2 → IDLE with `sig_out`=0. Re-enable → full 4-cycle gap. Separately, `rst` in ACTIVE → all outputs 0 and `active_grp`=0 after the edge.
- **Data path:** ACTIVE on group 1, toggle `sig_in` 01→10→11 on consecutive cycles → `sig_out`[3:2] follows with 1-cycle latency; `sig_out`[1:0] stays 0.
